// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI host: FSM states, latched transfer
// configuration and the SPI mode encodings.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    TRAIL
  } spi_state_t;

  // Per-transfer settings captured when a request is accepted
  typedef struct packed {
    logic cpol;
    logic cpha;
    logic cs_hold;
    logic lsbf;
  } spi_cfg_t;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage : spi_pkg

// File: rtl/spi_clkdiv.sv
// SCK half-period divider: emits a tick every div+1 ce-qualified cycles,
// restarting the count from div whenever reload is pulsed.
module spi_clkdiv #(
  parameter int unsigned DIVW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ce,
  input  logic [DIVW-1:0] div,
  input  logic            reload,
  output logic            tick_c
);

  logic [DIVW-1:0] divcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divcnt <= '0;
    end else if (ce) begin
      if (reload || (divcnt == '0)) begin
        divcnt <= div;
      end else begin
        divcnt <= divcnt - DIVW'(1);
      end
    end
  end

  assign tick_c = ce & (divcnt == '0);

endmodule : spi_clkdiv

// File: rtl/spi_master.sv
// Parametrised SPI host with wr/dsr word handshake, selectable mode, divider,
// chip select and CS hold. Define SPI_LSBF_EN to add the lsbf (LSB-first) input.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned  DW   = 8,
  parameter int unsigned  DIVW = 8,
  parameter int unsigned  NCS  = 2,
  localparam int unsigned CSW  = $clog2(NCS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ce,
  input  logic [DIVW-1:0] div,
  input  logic            cpol,
  input  logic            cpha,
  input  logic [CSW-1:0]  cs_sel,
  input  logic            cs_hold,
`ifdef SPI_LSBF_EN
  input  logic            lsbf,
`endif
  input  logic [DW-1:0]   di,
  input  logic            wr,
  output logic [DW-1:0]   dout,
  output logic            dsr,
  output logic            busy,
  output logic            sck,
  output logic            mosi,
  input  logic            miso,
  output logic [NCS-1:0]  cs_n
);

  localparam int unsigned EW = $clog2(2 * DW);

  spi_state_t      state, state_nxt;
  spi_cfg_t        cfg_q, cfg_nxt;
  logic [DIVW-1:0] div_q, div_nxt;
  logic [DW-1:0]   shreg, shreg_nxt;
  logic [EW-1:0]   edge_cnt, edge_nxt;
  logic            sck_nxt, mosi_nxt, dsr_nxt, busy_nxt;
  logic [NCS-1:0]  cs_n_nxt;

  logic            lsbf_in_c;
  logic            accept_c;
  logic            tick_c;
  logic            last_edge_c;
  logic            sample_c;
  logic [DIVW-1:0] div_eff_c;

`ifdef SPI_LSBF_EN
  assign lsbf_in_c = lsbf;
`else
  assign lsbf_in_c = 1'b0;
`endif

  assign accept_c    = ce & wr & (state == IDLE);
  assign last_edge_c = (edge_cnt == EW'(2 * DW - 1));
  // Even edges are leading; cpha picks whether the leading edge samples
  assign sample_c    = (edge_cnt[0] == cfg_q.cpha);
  assign div_eff_c   = accept_c ? div : div_q;

  spi_clkdiv #(
    .DIVW (DIVW)
  ) u_clkdiv (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .div    (div_eff_c),
    .reload (accept_c),
    .tick_c (tick_c)
  );

  // One-cold decode; codes at or above NCS leave every line deasserted
  function automatic logic [NCS-1:0] cs_decode(input logic [CSW-1:0] sel);
    logic [NCS-1:0] v;
    v = '1;
    for (int i = 0; i < NCS; i++) begin
      if (sel == CSW'(i)) v[i] = 1'b0;
    end
    return v;
  endfunction

  function automatic logic out_bit(input logic [DW-1:0] sh, input logic lsb);
    return lsb ? sh[0] : sh[DW-1];
  endfunction

  function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] sh, input logic lsb,
                                             input logic bit_in);
    return lsb ? {bit_in, sh[DW-1:1]} : {sh[DW-2:0], bit_in};
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept_c) state_nxt = SETUP;
      SETUP:   if (tick_c) state_nxt = SHIFT;
      SHIFT:   if (tick_c && last_edge_c) state_nxt = TRAIL;
      TRAIL:   if (tick_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    cfg_nxt   = cfg_q;
    div_nxt   = div_q;
    shreg_nxt = shreg;
    edge_nxt  = edge_cnt;
    sck_nxt   = sck;
    mosi_nxt  = mosi;
    dsr_nxt   = dsr;
    busy_nxt  = busy;
    cs_n_nxt  = cs_n;
    unique case (state)
      IDLE: begin
        if (ce) sck_nxt = cpol;
        if (accept_c) begin
          cfg_nxt   = '{cpol: cpol, cpha: cpha, cs_hold: cs_hold, lsbf: lsbf_in_c};
          div_nxt   = div;
          shreg_nxt = di;
          edge_nxt  = '0;
          cs_n_nxt  = cs_decode(cs_sel);
          dsr_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          if (!cpha) mosi_nxt = out_bit(di, lsbf_in_c);
        end
      end
      SHIFT: begin
        if (tick_c) begin
          sck_nxt  = ~sck;
          edge_nxt = edge_cnt + EW'(1);
          if (sample_c) begin
            shreg_nxt = shift_in(shreg, cfg_q.lsbf, miso);
          end else if (!last_edge_c) begin
            mosi_nxt = out_bit(shreg, cfg_q.lsbf);
          end
        end
      end
      TRAIL: begin
        if (tick_c) begin
          mosi_nxt = 1'b0;
          dsr_nxt  = 1'b1;
          busy_nxt = 1'b0;
          if (!cfg_q.cs_hold) cs_n_nxt = '1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_q    <= '0;
      div_q    <= '0;
      shreg    <= '0;
      edge_cnt <= '0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      dsr      <= 1'b0;
      busy     <= 1'b0;
      cs_n     <= '1;
    end else begin
      cfg_q    <= cfg_nxt;
      div_q    <= div_nxt;
      shreg    <= shreg_nxt;
      edge_cnt <= edge_nxt;
      sck      <= sck_nxt;
      mosi     <= mosi_nxt;
      dsr      <= dsr_nxt;
      busy     <= busy_nxt;
      cs_n     <= cs_n_nxt;
    end
  end

  assign dout = shreg;

endmodule : spi_master

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback and slave-model transfers, CS hold,
// ignored wr, mid-transfer reset and (with SPI_LSBF_EN) LSB-first ordering.
module tb_spi_master;
  import spi_pkg::*;

  localparam int unsigned DW   = 8;
  localparam int unsigned DIVW = 8;
  localparam int unsigned NCS  = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            ce;
  logic [DIVW-1:0] div;
  logic            cpol, cpha;
  logic [0:0]      cs_sel;
  logic            cs_hold;
  logic [DW-1:0]   di;
  logic            wr;
  logic [DW-1:0]   dout;
  logic            dsr, busy, sck, mosi, miso;
  logic [NCS-1:0]  cs_n;
`ifdef SPI_LSBF_EN
  logic            lsbf;
`endif

  // Slave model state
  logic            loop_en;
  logic            miso_r = 1'b0;
  logic            sck_d = 1'b0;
  logic [DW-1:0]   sl_sh = '0;
  logic            sl_load;
  logic [DW-1:0]   sl_load_val;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign miso = loop_en ? mosi : miso_r;

  spi_master #(
    .DW   (DW),
    .DIVW (DIVW),
    .NCS  (NCS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ce      (ce),
    .div     (div),
    .cpol    (cpol),
    .cpha    (cpha),
    .cs_sel  (cs_sel),
    .cs_hold (cs_hold),
`ifdef SPI_LSBF_EN
    .lsbf    (lsbf),
`endif
    .di      (di),
    .wr      (wr),
    .dout    (dout),
    .dsr     (dsr),
    .busy    (busy),
    .sck     (sck),
    .mosi    (mosi),
    .miso    (miso),
    .cs_n    (cs_n)
  );

  // Simple SPI slave: drives on leading edges, samples on trailing edges
  always @(negedge clk) begin
    sck_d <= sck;
    if (sl_load) begin
      sl_sh <= sl_load_val;
    end else if (!cs_n[cs_sel] && (sck !== sck_d)) begin
      if (sck_d == cpol) miso_r <= sl_sh[DW-1];
      else               sl_sh  <= {sl_sh[DW-2:0], mosi};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one word; reports latency, SCK rises, period, line bits at SCK rises
  task automatic xfer(input logic [DW-1:0] d, input logic pol, input logic pha,
                      input logic [0:0] sel, input logic hold, input logic [DIVW-1:0] dv,
                      input int pulse_at,
                      output int lat, output int rises, output int period,
                      output logic [DW-1:0] cap, output logic stable, output logic cs_gap,
                      output logic busy_ok, output logic first_mosi);
    int   first_rise;
    logic psck, pmosi;
    @(negedge clk);
    di = d; cpol = pol; cpha = pha; cs_sel = sel; cs_hold = hold; div = dv; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
    first_mosi = mosi;
    busy_ok = busy;
    lat = 0; rises = 0; period = 0; cap = '0; stable = 1'b1; cs_gap = 1'b0; first_rise = 0;
    for (int k = 1; k <= 4000; k++) begin
      psck = sck;
      pmosi = mosi;
      if (k == pulse_at) begin
        wr = 1'b1;
        di = '1;
      end else begin
        wr = 1'b0;
      end
      @(posedge clk); #1;
      if (dsr) begin
        lat = k;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (cs_n[sel]) cs_gap = 1'b1;
      if (!psck && sck) begin
        rises++;
        cap = {cap[DW-2:0], mosi};
        if (mosi !== pmosi) stable = 1'b0;
        if (rises == 1) first_rise = k;
        else if (rises == 2) period = k - first_rise;
      end
    end
    wr = 1'b0;
  endtask

  initial begin
    int            lat, rises, period, toggles;
    logic [DW-1:0] cap;
    logic          stable, cs_gap, busy_ok, fm, psck;
    logic [1:0]    modes [4];

    modes[0] = SPI_MODE0; modes[1] = SPI_MODE1; modes[2] = SPI_MODE2; modes[3] = SPI_MODE3;
    reset = 1'b1; ce = 1'b1; wr = 1'b0; di = '0; div = '0;
    cpol = 1'b0; cpha = 1'b0; cs_sel = 1'b0; cs_hold = 1'b0;
    loop_en = 1'b1; sl_load = 1'b0; sl_load_val = '0;
`ifdef SPI_LSBF_EN
    lsbf = 1'b0;
`endif

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_sck",  32'(sck),  32'h0);
    check("rst_mosi", 32'(mosi), 32'h0);
    check("rst_dsr",  32'(dsr),  32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cs_n", 32'(cs_n), 32'h3);
    check("rst_dout", 32'(dout), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Idle SCK level follows cpol in every mode
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      {cpol, cpha} = modes[i];
      @(posedge clk); #1;
      check("idle_sck_mode", 32'(sck), 32'(modes[i][1]));
    end

    // ce low: nothing advances, wr not accepted
    @(negedge clk);
    ce = 1'b0; cpol = 1'b0; wr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ce_low_sck",  32'(sck),  32'h1);
    check("ce_low_busy", 32'(busy), 32'h0);
    @(negedge clk);
    wr = 1'b0; ce = 1'b1;
    repeat (2) @(posedge clk);

    // Mode 0, div 0, loopback A5
    xfer(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, -1,
         lat, rises, period, cap, stable, cs_gap, busy_ok, fm);
    check("m0_latency",   32'(lat),     32'd18);
    check("m0_rises",     32'(rises),   32'd8);
    check("m0_period",    32'(period),  32'd2);
    check("m0_line_bits", 32'(cap),     32'hA5);
    check("m0_stable",    32'(stable),  32'h1);
    check("m0_first_bit", 32'(fm),      32'h1);
    check("m0_busy",      32'(busy_ok), 32'h1);
    check("m0_cs_low",    32'(cs_gap),  32'h0);
    check("m0_dout",      32'(dout),    32'hA5);
    check("m0_cs_after",  32'(cs_n),    32'h3);
    check("m0_mosi_idle", 32'(mosi),    32'h0);

    // Mode 3, div 3, slave returns 3C
    @(negedge clk);
    loop_en = 1'b0; cpol = 1'b1; cpha = 1'b1; sl_load_val = 8'h3C; sl_load = 1'b1;
    @(negedge clk); #1;
    sl_load = 1'b0;
    @(posedge clk); #1;
    check("m3_idle_high", 32'(sck), 32'h1);
    xfer(8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3, -1,
         lat, rises, period, cap, stable, cs_gap, busy_ok, fm);
    check("m3_latency",   32'(lat),    32'd72);
    check("m3_rises",     32'(rises),  32'd8);
    check("m3_period",    32'(period), 32'd8);
    check("m3_line_bits", 32'(cap),    32'hC3);
    check("m3_dout",      32'(dout),   32'h3C);
    @(negedge clk);
    check("m3_slave_rx",  32'(sl_sh),  32'hC3);
    check("m3_sck_end",   32'(sck),    32'h1);
    loop_en = 1'b1;

    // CS hold across three words to device 1
    xfer(8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, -1,
         lat, rises, period, cap, stable, cs_gap, busy_ok, fm);
    check("hold1_dout",  32'(dout),   32'h11);
    check("hold1_gap",   32'(cs_gap), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("hold1_cs",    32'(cs_n),   32'h1);
    xfer(8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, -1,
         lat, rises, period, cap, stable, cs_gap, busy_ok, fm);
    check("hold2_dout",  32'(dout),   32'h22);
    check("hold2_gap",   32'(cs_gap), 32'h0);
    check("hold2_cs",    32'(cs_n),   32'h1);
    xfer(8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, -1,
         lat, rises, period, cap, stable, cs_gap, busy_ok, fm);
    check("hold3_dout",  32'(dout),   32'h33);
    check("hold3_gap",   32'(cs_gap), 32'h0);
    check("hold3_cs",    32'(cs_n),   32'h3);

    // wr pulse during SHIFT is ignored and not queued
    xfer(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8,
         lat, rises, period, cap, stable, cs_gap, busy_ok, fm);
    check("ign_latency", 32'(lat),  32'd36);
    check("ign_dout",    32'(dout), 32'h5A);
    repeat (40) @(posedge clk);
    #1;
    check("ign_dsr",     32'(dsr),  32'h1);
    check("ign_busy",    32'(busy), 32'h0);
    check("ign_dout2",   32'(dout), 32'h5A);

    // Reset at SCK edge 5 of a transfer
    @(negedge clk);
    di = 8'h96; cpol = 1'b0; cpha = 1'b0; cs_sel = 1'b0; cs_hold = 1'b1; div = 8'd1; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
    toggles = 0;
    for (int k = 0; k < 200; k++) begin
      psck = sck;
      @(posedge clk); #1;
      if (sck !== psck) toggles++;
      if (toggles == 5) break;
    end
    check("mid_edges",   32'(toggles), 32'd5);
    reset = 1'b1;
    #1;
    check("mid_cs_n",    32'(cs_n), 32'h3);
    check("mid_sck",     32'(sck),  32'h0);
    check("mid_mosi",    32'(mosi), 32'h0);
    check("mid_busy",    32'(busy), 32'h0);
    check("mid_dsr",     32'(dsr),  32'h0);
    check("mid_dout",    32'(dout), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    xfer(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, -1,
         lat, rises, period, cap, stable, cs_gap, busy_ok, fm);
    check("post_latency", 32'(lat),  32'd18);
    check("post_dout",    32'(dout), 32'h96);
    check("post_bits",    32'(cap),  32'h96);

`ifdef SPI_LSBF_EN
    // LSB first, loopback
    lsbf = 1'b1;
    xfer(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, -1,
         lat, rises, period, cap, stable, cs_gap, busy_ok, fm);
    check("lsbf_first_bit", 32'(fm),   32'h1);
    check("lsbf_line_bits", 32'(cap),  32'h80);
    check("lsbf_dout",      32'(dout), 32'h01);
    lsbf = 1'b0;
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_spi_master
